ysyx_22041752_msu: RTL and testbench
====================================

YSYX_22041752_MSU -- requirements
Module: ysyx_22041752_MSU

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ms_allowin  output  1  stage can accept from EX.
REQ-004 SHALL have port: es_to_ms_valid  input  1  EX holds a valid instruction.
REQ-005 SHALL have port: es_to_ms_bus  input  203  MSB->LSB fields: {rf_we 1, rd 5, alu_result 64, mem_re 1, mem_we 1, mem_size 2 (0=B,1=H,2=W,3=D), mem_unsigned 1, store_data 64, pc 64}.
REQ-006 SHALL have port: ws_allowin  input  1  WB can accept.
REQ-007 SHALL have port: ms_to_ws_valid  output  1  instruction handed to WB.
REQ-008 SHALL have port: ms_to_ws_bus  output  134  {rf_we 1, rd 5, result 64, pc 64}.
REQ-009 SHALL have port: ms_forward_bus  output  70  {fwd_valid 1, result 64, rd 5}.
REQ-010 SHALL have port: ms_load_pending  output  1  valid load in stage, data not yet returned.
REQ-011 SHALL have ports: data_req  output  1; data_wr  output  1; data_addr  output  64; data_wstrb  output  8; data_wdata  output  64; data_addr_ok  input  1; data_data_ok  input  1; data_rdata  input  64.

Function
REQ-012 SHALL latch es_to_ms_bus and set ms_valid<=es_to_ms_valid when ms_allowin=1.
REQ-013 SHALL keep FSM states IDLE, REQ, WAIT, DONE; on accept, next state = REQ if (mem_re|mem_we) & es_to_ms_valid, else IDLE.
REQ-014 SHALL drive data_req=1 only in REQ; REQ->WAIT on data_addr_ok; address, strobe, data, data_wr held stable while in REQ.
REQ-015 SHALL move WAIT->DONE on data_data_ok, capturing data_rdata; data_data_ok in IDLE/REQ/DONE SHALL be ignored.
REQ-016 SHALL treat data_data_ok as arriving at least one cycle after data_addr_ok (no same-cycle completion).
REQ-017 SHALL set ms_ready_go = !(mem_re|mem_we) | (state==DONE); ms_to_ws_valid = ms_valid & ms_ready_go; ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
REQ-018 SHALL leave DONE when WB accepts: to REQ/IDLE per newly latched instruction, else IDLE.
REQ-019 SHALL set data_addr = alu_result, data_wr = mem_we; store wstrb: B=1<<a[2:0], H=3<<a[2:0], W=0xF<<a[2:0], D=0xFF; wdata = store_data low bytes replicated across 64 bits.
REQ-020 SHALL form load result by selecting byte a[2:0], half a[2:1], word a[2] or full dword, sign-extended unless mem_unsigned; non-loads pass alu_result.
REQ-021 SHALL set ms_to_ws_bus rf_we = latched rf_we; fwd_valid = ms_valid & rf_we & !ms_load_pending.
REQ-022 SHALL hold all ms_to_ws_bus fields stable while ms_to_ws_valid=1 and ws_allowin=0.

Reset
REQ-023 SHALL, on reset low, immediately force state=IDLE, ms_valid=0, data_req=0, ms_to_ws_valid=0, ms_load_pending=0, fwd_valid=0; data buses don't-care.
REQ-024 SHALL, after reset mid-transaction, drop any later data_data_ok for the aborted access.

Configuration
REQ-025 SHALL support macro YSYX_22041752_MS_MISALIGN_CHECK_EN: defined -> H/W/D access with address not size-aligned issues no request, goes directly to DONE, asserts output ms_misalign (1 bit) with rf_we forced 0; undefined -> no ms_misalign port, address issued unmodified.

Verification
REQ-026 SHALL cover: ALU op rd=5 result 0x1234, ws_allowin=1 -> ms_to_ws_valid 1 cycle after accept, no data_req.
REQ-027 SHALL cover: lb addr 0x...03, rdata 0x0000_0000_8000_0000 -> hmm byte3=0x80 -> result 0xFFFF_FFFF_FFFF_FF80; lbu -> 0x80.
REQ-028 SHALL cover: sh addr 0x...06, store_data 0xABCD -> wstrb 0xC0, wdata 0xABCD_ABCD_ABCD_ABCD, data_wr=1.
REQ-029 SHALL cover: addr_ok delayed 3 cycles, data_ok 2 more, ws_allowin=0 for 2 cycles in DONE -> req held, bus stable, exactly one handoff.
REQ-030 SHALL cover: reset asserted in WAIT then released, stale data_data_ok pulsed -> state IDLE, ms_to_ws_valid stays 0.

Source files
------------

// File: rtl/ysyx_22041752_msu.sv
// Memory stage: latches the EX bundle, runs a req/addr_ok/data_ok handshake for loads/stores, shapes results for WB.
// Optional YSYX_22041752_MS_MISALIGN_CHECK_EN adds ms_misalign and suppresses requests for misaligned H/W/D accesses.
module ysyx_22041752_msu (
    input  logic         clk,
    input  logic         reset,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [202:0] es_to_ms_bus,
    input  logic         ws_allowin,
    output logic         ms_to_ws_valid,
    output logic [133:0] ms_to_ws_bus,
    output logic [69:0]  ms_forward_bus,
    output logic         ms_load_pending,
    output logic         data_req,
    output logic         data_wr,
    output logic [63:0]  data_addr,
    output logic [7:0]   data_wstrb,
    output logic [63:0]  data_wdata,
    input  logic         data_addr_ok,
    input  logic         data_data_ok,
`ifdef YSYX_22041752_MS_MISALIGN_CHECK_EN
    input  logic [63:0]  data_rdata,
    output logic         ms_misalign
`else
    input  logic [63:0]  data_rdata
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        state_q, acc_state_d;
    logic          ms_valid_q;
    logic [202:0]  bus_q;
    logic [63:0]   rdata_q;
    logic          misalign_q, misalign_d;

    logic          rf_we, mem_re, mem_we, mem_uns, ms_ready_go, rf_we_eff, fwd_valid;
    logic [4:0]    rd;
    logic [63:0]   alu_res, st_data, pc, result;
    logic [1:0]    mem_size;
    logic [63:0]   byte_sh, half_sh, word_sh;

    assign {rf_we, rd, alu_res, mem_re, mem_we, mem_size, mem_uns, st_data, pc} = bus_q;

    // Accept-time decode works on the incoming bundle, not the latched one.
    always_comb begin
        misalign_d = 1'b0;
`ifdef YSYX_22041752_MS_MISALIGN_CHECK_EN
        case (es_to_ms_bus[130:129])
            2'd1:    misalign_d = es_to_ms_bus[133];
            2'd2:    misalign_d = |es_to_ms_bus[134:133];
            2'd3:    misalign_d = |es_to_ms_bus[135:133];
            default: misalign_d = 1'b0;
        endcase
        misalign_d = misalign_d & (es_to_ms_bus[132] | es_to_ms_bus[131]) & es_to_ms_valid;
`endif
        if (es_to_ms_valid && (es_to_ms_bus[132] || es_to_ms_bus[131]))
            acc_state_d = misalign_d ? S_DONE : S_REQ;
        else
            acc_state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ms_valid_q <= 1'b0;
            bus_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_q <= es_to_ms_valid;
            bus_q      <= es_to_ms_bus;
            state_q    <= acc_state_d;
            misalign_q <= misalign_d;
        end else begin
            case (state_q)
                S_REQ:  if (data_addr_ok) state_q <= S_WAIT;
                S_WAIT: if (data_data_ok) begin
                    state_q <= S_DONE;
                    rdata_q <= data_rdata;
                end
                default: ;
            endcase
        end
    end

    assign ms_ready_go     = !(mem_re || mem_we) || (state_q == S_DONE);
    assign ms_to_ws_valid  = ms_valid_q && ms_ready_go;
    assign ms_allowin      = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_load_pending = ms_valid_q && mem_re && (state_q != S_DONE);

    assign data_req  = (state_q == S_REQ);
    assign data_wr   = mem_we;
    assign data_addr = alu_res;

    always_comb begin
        data_wstrb = 8'h00;
        data_wdata = st_data;
        case (mem_size)
            2'd0: begin
                data_wstrb = 8'h01 << alu_res[2:0];
                data_wdata = {8{st_data[7:0]}};
            end
            2'd1: begin
                data_wstrb = 8'h03 << alu_res[2:0];
                data_wdata = {4{st_data[15:0]}};
            end
            2'd2: begin
                data_wstrb = 8'h0F << alu_res[2:0];
                data_wdata = {2{st_data[31:0]}};
            end
            default: data_wstrb = 8'hFF;
        endcase
        if (!mem_we) data_wstrb = 8'h00;
    end

    assign byte_sh = rdata_q >> {alu_res[2:0], 3'b000};
    assign half_sh = rdata_q >> {alu_res[2:1], 4'b0000};
    assign word_sh = rdata_q >> {alu_res[2], 5'b00000};

    always_comb begin
        result = alu_res;
        if (mem_re) begin
            case (mem_size)
                2'd0:    result = mem_uns ? {56'd0, byte_sh[7:0]}  : {{56{byte_sh[7]}},  byte_sh[7:0]};
                2'd1:    result = mem_uns ? {48'd0, half_sh[15:0]} : {{48{half_sh[15]}}, half_sh[15:0]};
                2'd2:    result = mem_uns ? {32'd0, word_sh[31:0]} : {{32{word_sh[31]}}, word_sh[31:0]};
                default: result = rdata_q;
            endcase
        end
    end

    // A misaligned access completes as a faulting no-op with its writeback squashed.
    assign rf_we_eff      = rf_we && !misalign_q;
    assign fwd_valid      = ms_valid_q && rf_we_eff && !ms_load_pending;
    assign ms_to_ws_bus   = {rf_we_eff, rd, result, pc};
    assign ms_forward_bus = {fwd_valid, result, rd};

`ifdef YSYX_22041752_MS_MISALIGN_CHECK_EN
    assign ms_misalign = ms_valid_q && misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_22041752_msu.sv
// Scoreboard bench for the memory stage: stimulus pushes expected WB/request records, monitors pop and compare.
module tb_ysyx_22041752_msu;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ms_allowin;
    logic         es_to_ms_valid = 1'b0;
    logic [202:0] es_to_ms_bus = '0;
    logic         ws_allowin = 1'b1;
    logic         ms_to_ws_valid;
    logic [133:0] ms_to_ws_bus;
    logic [69:0]  ms_forward_bus;
    logic         ms_load_pending;
    logic         data_req, data_wr;
    logic [63:0]  data_addr, data_wdata;
    logic [7:0]   data_wstrb;
    logic         data_addr_ok = 1'b0;
    logic         data_data_ok = 1'b0;
    logic [63:0]  data_rdata = '0;
`ifdef YSYX_22041752_MS_MISALIGN_CHECK_EN
    logic         ms_misalign;
`endif

    ysyx_22041752_msu dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_to_ws_bus(ms_to_ws_bus), .ms_forward_bus(ms_forward_bus),
        .ms_load_pending(ms_load_pending), .data_req(data_req), .data_wr(data_wr),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
`ifdef YSYX_22041752_MS_MISALIGN_CHECK_EN
        .ms_misalign(ms_misalign),
`endif
        .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int handoffs = 0;
    logic [133:0] exp_q[$];
    logic [136:0] req_q[$];

    // Memory responder knobs
    logic        resp_en = 1'b1;
    int          addr_dly = 0;
    int          data_dly = 0;
    logic [63:0] mem_rdata = '0;
    logic [63:0] pc_ctr = 64'h8000_0000;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [202:0] mk(input logic rfw, input logic [4:0] rd, input logic [63:0] alu,
                                        input logic re, input logic we, input logic [1:0] sz,
                                        input logic uns, input logic [63:0] sd, input logic [63:0] pc);
        return {rfw, rd, alu, re, we, sz, uns, sd, pc};
    endfunction

    // Responder: addr_ok after addr_dly cycles of req, data_ok data_dly cycles later.
    always begin
        @(posedge clk); #1;
        if (resp_en && data_req) begin
            for (int i = 0; i < addr_dly; i++) begin @(posedge clk); #1; end
            data_addr_ok = 1'b1;
            @(posedge clk); #1;
            data_addr_ok = 1'b0;
            for (int i = 0; i < data_dly; i++) begin @(posedge clk); #1; end
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
            @(posedge clk); #1;
            data_data_ok = 1'b0;
        end
    end

    // Monitors: WB handoffs, memory requests, and stability of held outputs.
    logic         hold_prev = 1'b0;
    logic [133:0] prev_bus;
    logic         req_prev = 1'b0;
    logic [136:0] prev_req;
    always @(negedge clk) begin
        logic [133:0] e;
        logic [136:0] r;
        if (ms_to_ws_valid && hold_prev) chk("wb_bus_stable", ms_to_ws_bus, prev_bus);
        hold_prev = ms_to_ws_valid && !ws_allowin;
        prev_bus  = ms_to_ws_bus;
        if (ms_to_ws_valid && ws_allowin) begin
            handoffs++;
            if (exp_q.size() == 0) chk("unexpected_handoff", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("wb_bus", ms_to_ws_bus, e);
                chk("fwd_bus", ms_forward_bus, {e[133], e[127:64], e[132:128]});
            end
        end
        r = {data_wr, data_addr, data_wstrb, data_wdata};
        if (data_req && req_prev) chk("req_stable", r, prev_req);
        req_prev = data_req;
        prev_req = r;
        if (data_req && data_addr_ok) begin
            if (req_q.size() == 0) chk("unexpected_req", 1, 0);
            else chk("req", r, req_q.pop_front());
        end
    end

    task automatic issue(input logic [202:0] b, input logic push, input logic [133:0] e,
                         input logic push_req, input logic [136:0] r);
        int n = 0;
        @(posedge clk); #1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        if (push) exp_q.push_back(e);
        if (push_req) req_q.push_back(r);
        @(negedge clk);
        while (!ms_allowin && n < 50) begin n++; @(negedge clk); end
        if (!ms_allowin) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        pc_ctr += 4;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && n < 100) begin n++; @(negedge clk); end
        if (exp_q.size() != 0 || req_q.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    task automatic ld(input logic [4:0] rd, input logic [63:0] a, input logic [1:0] sz,
                      input logic uns, input logic [63:0] rdat, input logic [63:0] res);
        mem_rdata = rdat;
        issue(mk(1'b1, rd, a, 1'b1, 1'b0, sz, uns, 64'd0, pc_ctr), 1'b1, {1'b1, rd, res, pc_ctr},
              1'b1, {1'b0, a, 8'h00, 64'd0});
        drain();
    endtask

    task automatic st(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] sd,
                      input logic [7:0] strb, input logic [63:0] wd);
        issue(mk(1'b0, 5'd0, a, 1'b0, 1'b1, sz, 1'b0, sd, pc_ctr), 1'b1, {1'b0, 5'd0, a, pc_ctr},
              1'b1, {1'b1, a, strb, wd});
        drain();
    endtask

    initial begin
        int n, h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_allowin", ms_allowin, 1);
        chk("rst_to_ws_valid", ms_to_ws_valid, 0);
        chk("rst_data_req", data_req, 0);
        chk("rst_load_pending", ms_load_pending, 0);
        chk("rst_fwd_valid", ms_forward_bus[69], 0);
        @(posedge clk); #1 reset = 1'b1;

        // ALU op: handoff one cycle after accept, no memory request
        issue(mk(1'b1, 5'd5, 64'h1234, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, pc_ctr), 1'b1,
              {1'b1, 5'd5, 64'h1234, pc_ctr}, 1'b0, '0);
        @(negedge clk);
        chk("alu_latency", ms_to_ws_valid, 1);
        chk("alu_no_req", data_req, 0);
        drain();

        // Loads
        ld(5'd6,  64'h1003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        ld(5'd7,  64'h1003, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        ld(5'd8,  64'h1002, 2'd1, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_8000);
        ld(5'd10, 64'h2000, 2'd2, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_9ABC_DEF0);
        ld(5'd11, 64'h2004, 2'd2, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_1234_5678);
        ld(5'd12, 64'h2006, 2'd1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_1234);
        ld(5'd13, 64'h2008, 2'd3, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);

        // Stores
        st(64'h3006, 2'd1, 64'hABCD,      8'hC0, 64'hABCD_ABCD_ABCD_ABCD);
        st(64'h3005, 2'd0, 64'h5A,        8'h20, 64'h5A5A_5A5A_5A5A_5A5A);
        st(64'h3004, 2'd2, 64'hDEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF);
        st(64'h3008, 2'd3, 64'h0102_0304_0506_0708, 8'hFF, 64'h0102_0304_0506_0708);

        // Slow memory plus WB backpressure in DONE
        addr_dly = 3; data_dly = 2; ws_allowin = 1'b0;
        h0 = handoffs;
        mem_rdata = 64'h0123_4567_89AB_CDEF;
        issue(mk(1'b1, 5'd9, 64'h4000, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0, pc_ctr), 1'b1,
              {1'b1, 5'd9, 64'h0123_4567_89AB_CDEF, pc_ctr}, 1'b1, {1'b0, 64'h4000, 8'h00, 64'd0});
        n = 0;
        @(negedge clk);
        while (!ms_to_ws_valid && n < 50) begin n++; @(negedge clk); end
        chk("slow_done_seen", ms_to_ws_valid, 1);
        repeat (2) @(negedge clk);
        chk("slow_held_valid", ms_to_ws_valid, 1);
        @(posedge clk); #1 ws_allowin = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        chk("slow_one_handoff", handoffs - h0, 1);
        addr_dly = 0; data_dly = 0;

        // Reset while waiting for data, then a stale data_ok
        resp_en = 1'b0;
        issue(mk(1'b1, 5'd14, 64'h5000, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0, pc_ctr), 1'b0, '0,
              1'b1, {1'b0, 64'h5000, 8'h00, 64'd0});
        n = 0;
        @(negedge clk);
        while (!data_req && n < 20) begin n++; @(negedge clk); end
        chk("abort_req_seen", data_req, 1);
        @(posedge clk); #1 data_addr_ok = 1'b1;
        @(posedge clk); #1 data_addr_ok = 1'b0;
        @(negedge clk);
        chk("wait_load_pending", ms_load_pending, 1);
        chk("wait_fwd_valid", ms_forward_bus[69], 0);
        #1 reset = 1'b0;
        #1;
        chk("abort_load_pending", ms_load_pending, 0);
        chk("abort_allowin", ms_allowin, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 data_data_ok = 1'b1; data_rdata = 64'hDEAD;
        @(posedge clk); #1 data_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_to_ws_valid", ms_to_ws_valid, 0);
            chk("stale_data_req", data_req, 0);
        end
        chk("queues_empty", exp_q.size() + req_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
